// File: rtl/spram_fifo_pkg.sv
// spram_fifo_pkg
//   Shared types and default widths for the single-port-RAM FIFO controller.
//   state_t     : controller FSM states (IDLE, RD_WAIT)
//   SPF_DATA_W  : default word width, matches the team RAM data width
//   SPF_ADDR_W  : default RAM address width
package spram_fifo_pkg;

  localparam int SPF_DATA_W = 8;
  localparam int SPF_ADDR_W = 6;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/spram_fifo_ctrl.sv
// spram_fifo_ctrl
//   Turns the shared single-port RAM (registered-address read) into a
//   valid/ready streaming FIFO. The one RAM port is shared between writes
//   and reads each cycle. A one-entry output register holds the head word,
//   so the consumer always sees a registered rd_data.
//
// Ports
//   clk, rst_n            : clock (rising edge, shared with the RAM), async active-low reset
//   wr_valid/wr_ready     : producer handshake, wr_data is the word offered
//   rd_valid/rd_ready     : consumer handshake, rd_data is the registered head word
//   count                 : words held in RAM + in flight + output register (0..DEPTH+1)
//   full                  : RAM holds DEPTH words
//   empty                 : count is zero
//   ram_data/addr/we      : drive the RAM port
//   ram_q                 : RAM read data, valid the cycle after the read address
module spram_fifo_ctrl
  import spram_fifo_pkg::*;
#(
  parameter int DATA_W = SPF_DATA_W,
  parameter int ADDR_W = SPF_ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_ram_cnt;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_pop;
  logic                w_rd_go;
  logic                w_wr_go;
  logic                w_in_flight;

  assign w_pop       = r_out_valid && rd_ready;
  assign w_in_flight = (r_state == RD_WAIT);

  // A read launches only when the output register will be free by the time
  // the RAM data comes back (one RD_WAIT cycle later).
  assign w_rd_go = (r_state == IDLE) && (r_ram_cnt != '0) && (!r_out_valid || w_pop);

  // Reads own the port when they launch. The RD_WAIT cycle is free for a
  // write because ram_q reflects the address latched in the previous cycle.
  // wr_ready is held low while reset is asserted.
  assign wr_ready = rst_n && !w_rd_go && (r_ram_cnt < LP_DEPTH);
  assign w_wr_go  = wr_valid && wr_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and RAM port drive; an idle port drives all zeros
  always_comb begin
    w_next_state = r_state;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_data     = '0;
    case (r_state)
      IDLE:    if (w_rd_go) w_next_state = RD_WAIT;
      RD_WAIT: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (w_rd_go) begin
      ram_addr = r_rd_ptr;
    end else if (w_wr_go) begin
      ram_we   = 1'b1;
      ram_addr = r_wr_ptr;
      ram_data = wr_data;
    end
  end

  // Pointers and RAM occupancy; writes and read launches never share a cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
    end else begin
      if (w_wr_go) begin
        r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
        r_ram_cnt <= r_ram_cnt + (ADDR_W + 1)'(1);
      end else if (w_rd_go) begin
        r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
        r_ram_cnt <= r_ram_cnt - (ADDR_W + 1)'(1);
      end
    end
  end

  // Output register: a refill from RD_WAIT wins over a pop, although a pop
  // cannot actually coincide with RD_WAIT since the register is empty then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_rd_data   <= '0;
    end else if (r_state == RD_WAIT) begin
      r_out_valid <= 1'b1;
      r_rd_data   <= ram_q;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  assign rd_valid = r_out_valid;
  assign rd_data  = r_rd_data;
  assign count    = r_ram_cnt + {{ADDR_W{1'b0}}, w_in_flight} + {{ADDR_W{1'b0}}, r_out_valid};
  assign full     = (r_ram_cnt == LP_DEPTH);
  assign empty    = (count == '0);

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// tb_spram_fifo_ctrl
//   Directed and random streaming checks of spram_fifo_ctrl against a
//   behavioural model of the team single-port RAM and a scoreboard queue.
module tb_spram_fifo_ctrl;

  logic       clk;
  logic       rstN;
  logic       wrValid;
  logic       wrReady;
  logic [7:0] wrData;
  logic       rdValid;
  logic       rdReady;
  logic [7:0] rdData;
  logic [6:0] count;
  logic       full;
  logic       empty;
  logic [7:0] ramData;
  logic [5:0] ramAddr;
  logic       ramWe;
  logic [7:0] ramQ;

  // Behavioural single-port RAM: registered read address
  logic [7:0] mem [64];
  logic [5:0] addrReg;

  int         nVectors;
  int         nMiscompares;
  logic [7:0] sbQ [$];
  int         popCycles [$];
  logic [5:0] expWrPtr;
  int         cycleCnt;
  int         firstWrCycle;
  int         firstValidCycle;
  int         totalAcc;
  int         nPops;
  logic       lastAcc;
  logic       prevHold;
  logic [7:0] prevData;

  spram_fifo_ctrl dut (
    .clk      (clk),
    .rst_n    (rstN),
    .wr_valid (wrValid),
    .wr_ready (wrReady),
    .wr_data  (wrData),
    .rd_valid (rdValid),
    .rd_ready (rdReady),
    .rd_data  (rdData),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ram_data (ramData),
    .ram_addr (ramAddr),
    .ram_we   (ramWe),
    .ram_q    (ramQ)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write on we, always latch the address for next-cycle read
  always @(posedge clk) begin
    if (ramWe) mem[ramAddr] <= ramData;
    addrReg <= ramAddr;
  end
  assign ramQ = mem[addrReg];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic reportTimeout(input string tag);
    nVectors++;
    nMiscompares++;
    $display("[TB] FAIL %s: observed timeout, expected completion", tag);
  endtask

  // One clock period: monitor/scoreboard at the falling edge, return 1 after the rising edge
  task automatic cycle();
    logic [7:0] expWord;
    @(negedge clk);
    lastAcc = 1'b0;
    checkOutput("count", 32'(count), 32'(sbQ.size()));
    checkOutput("empty", 32'(empty), 32'(sbQ.size() == 0));
    checkOutput("countMax", 32'(count <= 7'd65), 32'd1);
    if (prevHold && rdValid) checkOutput("rdStable", 32'(rdData), 32'(prevData));
    if (wrValid && wrReady) begin
      checkOutput("ramWe", 32'(ramWe), 32'd1);
      checkOutput("ramAddr", 32'(ramAddr), 32'(expWrPtr));
      checkOutput("ramData", 32'(ramData), 32'(wrData));
      sbQ.push_back(wrData);
      expWrPtr = expWrPtr + 6'd1;
      lastAcc  = 1'b1;
      totalAcc++;
      if (firstWrCycle < 0) firstWrCycle = cycleCnt;
    end
    if (rdValid && firstValidCycle < 0) firstValidCycle = cycleCnt;
    if (rdValid && rdReady) begin
      if (sbQ.size() == 0) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL popEmpty: observed pop of %0h, expected no data", rdData);
      end else begin
        expWord = sbQ.pop_front();
        checkOutput("rdData", 32'(rdData), 32'(expWord));
      end
      popCycles.push_back(cycleCnt);
      nPops++;
    end
    prevHold = rdValid && !rdReady;
    prevData = rdData;
    cycleCnt++;
    @(posedge clk);
    #1;
  endtask

  // Offer one word and wait (bounded) for it to be accepted; wrValid stays high
  task automatic applyStimulus(input logic [7:0] d);
    int n;
    wrValid = 1'b1;
    wrData  = d;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!lastAcc && n < 50);
    if (!lastAcc) reportTimeout("writeAccept");
  endtask

  task automatic drain(input int budget);
    int n;
    rdReady = 1'b1;
    n = 0;
    while (sbQ.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    if (sbQ.size() > 0) reportTimeout("drain");
    rdReady = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "RdValid"}, 32'(rdValid), 32'd0);
    checkOutput({tag, "RdData"},  32'(rdData),  32'd0);
    checkOutput({tag, "Count"},   32'(count),   32'd0);
    checkOutput({tag, "Empty"},   32'(empty),   32'd1);
    checkOutput({tag, "Full"},    32'(full),    32'd0);
    checkOutput({tag, "WrReady"}, 32'(wrReady), 32'd0);
    checkOutput({tag, "RamWe"},   32'(ramWe),   32'd0);
    checkOutput({tag, "RamAddr"}, 32'(ramAddr), 32'd0);
    checkOutput({tag, "RamData"}, 32'(ramData), 32'd0);
  endtask

  initial begin
    int n;
    int popsBefore;
    nVectors        = 0;
    nMiscompares    = 0;
    expWrPtr        = '0;
    cycleCnt        = 0;
    firstWrCycle    = -1;
    firstValidCycle = -1;
    totalAcc        = 0;
    nPops           = 0;
    lastAcc         = 1'b0;
    prevHold        = 1'b0;
    prevData        = '0;
    rstN    = 1'b0;
    wrValid = 1'b0;
    wrData  = '0;
    rdReady = 1'b0;

    // Reset state
    #3;
    checkResetValues("reset");
    cycle();
    cycle();
    rstN = 1'b1;
    #1;
    checkOutput("wrReadyAfterReset", 32'(wrReady), 32'd1);

    // Three back-to-back writes, consumer stalled
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    wrValid = 1'b0;
    repeat (4) cycle();
    checkOutput("latency", 32'(firstValidCycle - firstWrCycle), 32'd3);
    checkOutput("headValid", 32'(rdValid), 32'd1);
    checkOutput("headData", 32'(rdData), 32'h01);
    checkOutput("count3", 32'(count), 32'd3);

    // Drain at one pop per two cycles
    popCycles.delete();
    drain(20);
    checkOutput("pops3", 32'(popCycles.size()), 32'd3);
    if (popCycles.size() == 3) begin
      checkOutput("popGap1", 32'(popCycles[1] - popCycles[0]), 32'd2);
      checkOutput("popGap2", 32'(popCycles[2] - popCycles[1]), 32'd2);
    end
    cycle();
    checkOutput("emptyAfterDrain", 32'(empty), 32'd1);
    checkOutput("count0", 32'(count), 32'd0);

    // Fill to 65 words
    for (int i = 0; i <= 64; i++) applyStimulus(8'(i));
    wrValid = 1'b0;
    repeat (3) cycle();
    checkOutput("count65", 32'(count), 32'd65);
    checkOutput("full", 32'(full), 32'd1);
    checkOutput("wrReadyFull", 32'(wrReady), 32'd0);
    n = totalAcc;
    wrValid = 1'b1;
    wrData  = 8'h41;
    repeat (5) cycle();
    wrValid = 1'b0;
    checkOutput("overflowRejected", 32'(totalAcc - n), 32'd0);
    popsBefore = nPops;
    drain(200);
    checkOutput("pops65", 32'(nPops - popsBefore), 32'd65);

    // Read launch and write requested in the same cycle
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    wrValid = 1'b0;
    repeat (4) cycle();
    rdReady = 1'b1;
    wrValid = 1'b1;
    wrData  = 8'h5A;
    #1;
    checkOutput("arbRamWe", 32'(ramWe), 32'd0);
    checkOutput("arbWrReady", 32'(wrReady), 32'd0);
    checkOutput("arbRamAddr", 32'(ramAddr), 32'(6'(expWrPtr - 6'd1)));
    cycle();
    rdReady = 1'b0;
    #1;
    checkOutput("rdWaitWrReady", 32'(wrReady), 32'd1);
    checkOutput("rdWaitRamWe", 32'(ramWe), 32'd1);
    cycle();
    wrValid = 1'b0;
    drain(20);

    // Random traffic across pointer wrap
    n = 0;
    popsBefore = totalAcc;
    while (totalAcc - popsBefore < 200 && n < 6000) begin
      wrValid = 1'($urandom_range(0, 1));
      rdReady = 1'($urandom_range(0, 1));
      wrData  = 8'($urandom);
      cycle();
      n++;
    end
    wrValid = 1'b0;
    if (totalAcc - popsBefore < 200) reportTimeout("random200");
    drain(200);

    // Reset asserted during RD_WAIT with five words held
    for (int i = 0; i < 6; i++) applyStimulus(8'hC0 + 8'(i));
    wrValid = 1'b0;
    repeat (4) cycle();
    rdReady = 1'b1;
    cycle();
    rdReady = 1'b0;
    checkOutput("heldBeforeReset", 32'(count), 32'd5);
    rstN = 1'b0;
    #1;
    checkResetValues("midReset");
    sbQ.delete();
    expWrPtr = '0;
    prevHold = 1'b0;
    cycle();
    cycle();
    rstN = 1'b1;
    #1;
    checkOutput("wrReadyAfterMidReset", 32'(wrReady), 32'd1);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    wrValid = 1'b0;
    popsBefore = nPops;
    drain(20);
    checkOutput("popsAfterReset", 32'(nPops - popsBefore), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
